uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_ctrl_pkg.sv | 14 +
 rtl/rr_picker.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default sizing constants.
package uart_ctrl_pkg;

    localparam int unsigned DefaultDataW      = 8;
    localparam int unsigned DefaultAckTimeout = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitAck,
        StWaitDone
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin finder: index of the first set request at or after ptr_i, wrapping.
module rr_picker #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            found_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        // Walk offsets from farthest to nearest so the nearest set request is the last one kept.
        for (int k = int'(N) - 1; k >= 0; k--) begin
            cand = IdxW'((int'(ptr_i) + k) % int'(N));
            if (req_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams; the grant is
// held for a whole packet and a missing tx_busy acknowledge raises a sticky timeout flag.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = DefaultDataW,
    parameter int unsigned ACK_TIMEOUT = DefaultAckTimeout,
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [IdxW-1:0]           grant_id,
    output logic                      active,
    output logic                      err_timeout
);

    localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    arb_state_e        state_q, state_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              last_q, last_d;
    logic              tx_start_q, tx_start_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [IdxW-1:0]   pick_idx;
    logic              pick_found;
    logic              accept;
    logic              byte_done;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_picker #(
        .N (NUM_REQ)
    ) u_rr_picker (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign accept = (state_q == StSend) && req_valid[grant_q] && !tx_busy;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        tx_start_d = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;
        byte_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (accept) begin
                    tx_data_d  = data_arr[grant_q];
                    last_d     = req_last[grant_q];
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StWaitAck;
                end
            end
            StWaitAck: begin
                if (tx_busy) begin
                    cnt_d   = '0;
                    state_d = StWaitDone;
                end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                    // No acknowledge: flag it and move on as if the byte had gone out.
                    err_d     = 1'b1;
                    cnt_d     = '0;
                    byte_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (byte_done) begin
            if (last_q) begin
                state_d  = StIdle;
                rr_ptr_d = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end else begin
                state_d = StSend;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign active      = (state_q != StIdle);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a serial UART transmitter/receiver model pair.
module tb_uart_tx_arbiter;

    localparam int unsigned NumReq = 4;
    localparam int unsigned DataW  = 8;
    localparam int unsigned AckTo  = 16;
    localparam int unsigned IdxW   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NumReq-1:0]        req_valid;
    logic [NumReq*DataW-1:0]  req_data;
    logic [NumReq-1:0]        req_last;
    logic [NumReq-1:0]        req_ready;
    logic                     tx_start;
    logic [DataW-1:0]         tx_data;
    logic                     tx_busy;
    logic [IdxW-1:0]          grant_id;
    logic                     active;
    logic                     err_timeout;
    logic                     ser;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] gap;
    } src_t;

    typedef struct packed {
        logic [IdxW-1:0] id;
        logic [7:0]      data;
    } exp_t;

    src_t       src_q [NumReq][$];
    exp_t       exp_q [$];
    logic [7:0] rx_exp_q [$];
    int         wait_cnt [NumReq];
    int         n_total = 0;
    int         n_bad = 0;
    int         bit_cycles = 4;
    logic       no_ack = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ     (NumReq),
        .DATA_W      (DataW),
        .ACK_TIMEOUT (AckTo)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_src(input int r, input logic [7:0] d, input logic l, input int gap);
        src_t s;
        s.data = d;
        s.last = l;
        s.gap  = 8'(gap);
        src_q[r].push_back(s);
    endtask

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = IdxW'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic src_empty();
        logic empty;
        empty = 1'b1;
        for (int i = 0; i < NumReq; i++) begin
            if (src_q[i].size() != 0) empty = 1'b0;
        end
        return empty;
    endfunction

    task automatic drain(input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (rx_exp_q.size() == 0) && !active && !tx_busy
                   && src_empty();
        end
        check_eq("drain", done, 1);
    endtask

    // Requesters: each presents the head of its queue once its gap has elapsed.
    initial begin : source
        logic [NumReq-1:0] hs;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NumReq; i++) wait_cnt[i] = 0;
        forever begin
            @(negedge clk);
            hs = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NumReq; i++) begin
                if (hs[i]) begin
                    void'(src_q[i].pop_front());
                    wait_cnt[i] = 0;
                end else if (src_q[i].size() > 0) begin
                    wait_cnt[i]++;
                end
                if (src_q[i].size() > 0 && wait_cnt[i] >= int'(src_q[i][0].gap)) begin
                    req_valid[i]                = 1'b1;
                    req_data[i*DataW +: DataW] = src_q[i][0].data;
                    req_last[i]                 = src_q[i][0].last;
                end else begin
                    req_valid[i]                = 1'b0;
                    req_data[i*DataW +: DataW] = '0;
                    req_last[i]                 = 1'b0;
                end
            end
        end
    end

    initial begin : tx_model
        logic [7:0] b;
        tx_busy = 1'b0;
        ser     = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start && !no_ack) begin
                b = tx_data;
                @(posedge clk);
                #1;
                tx_busy = 1'b1;
                ser     = 1'b0;
                for (int k = 0; k < 9; k++) begin
                    repeat (bit_cycles) @(posedge clk);
                    #1;
                    ser = (k < 8) ? b[k] : 1'b1;
                end
                repeat (bit_cycles) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    initial begin : rx_model
        logic [7:0] b;
        int         bc;
        forever begin
            @(negedge clk);
            if (ser == 1'b0) begin
                bc = bit_cycles;
                repeat (bc + bc / 2) @(negedge clk);
                b[0] = ser;
                for (int j = 1; j < 8; j++) begin
                    repeat (bc) @(negedge clk);
                    b[j] = ser;
                end
                repeat (bc) @(negedge clk);
                check_eq("rx_stop", ser, 1);
                check_eq("rx_expected", rx_exp_q.size() > 0, 1);
                if (rx_exp_q.size() > 0) check_eq("rx_byte", b, rx_exp_q.pop_front());
            end
        end
    end

    initial begin : monitor
        exp_t       e;
        logic [7:0] cur_byte;
        logic       hold_ok;
        logic       busy_prev;
        cur_byte  = '0;
        hold_ok   = 1'b0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (req_ready != '0) check_eq("ready_onehot", $countones(req_ready), 1);
            if (rst) begin
                hold_ok = 1'b0;
            end else if (tx_start) begin
                check_eq("start_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("grant_id", grant_id, e.id);
                    check_eq("tx_data", tx_data, e.data);
                    cur_byte = e.data;
                    hold_ok  = 1'b1;
                    if (!no_ack) rx_exp_q.push_back(e.data);
                end
            end
            if (busy_prev && !tx_busy && hold_ok) check_eq("tx_data_hold", tx_data, cur_byte);
            busy_prev = tx_busy;
        end
    end

    initial begin : main
        logic found;
        int   k;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tx_start", tx_start, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_active", active, 0);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_err", err_timeout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte from requester 2: ready at n+1, start at n+2.
        push_src(2, 8'h5A, 1'b1, 0);
        push_exp(2, 8'h5A);
        found = 1'b0;
        for (int j = 0; j < 10 && !found; j++) begin
            @(negedge clk);
            found = req_valid[2];
        end
        check_eq("r37_valid_seen", found, 1);
        check_eq("r37_ready_n", req_ready, 0);
        @(negedge clk);
        check_eq("r37_ready_n1", req_ready, 4'b0100);
        check_eq("r37_start_n1", tx_start, 0);
        @(negedge clk);
        check_eq("r37_start_n2", tx_start, 1);
        check_eq("r37_data_n2", tx_data, 8'h5A);
        drain(300);

        // Pointer now 3: requester 3 beats requester 0.
        push_src(0, 8'h01, 1'b1, 0);
        push_src(3, 8'h03, 1'b1, 0);
        push_exp(3, 8'h03);
        push_exp(0, 8'h01);
        drain(300);

        // From pointer 0, all four valid: order 0,1,2,3,0.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_src(0, 8'hA0, 1'b1, 0);
        push_src(0, 8'hA4, 1'b1, 0);
        push_src(1, 8'hA1, 1'b1, 0);
        push_src(2, 8'hA2, 1'b1, 0);
        push_src(3, 8'hA3, 1'b1, 0);
        push_exp(0, 8'hA0);
        push_exp(1, 8'hA1);
        push_exp(2, 8'hA2);
        push_exp(3, 8'hA3);
        push_exp(0, 8'hA4);
        drain(600);

        // Packet lock across a 50-cycle gap while requester 0 waits.
        push_src(1, 8'h11, 1'b0, 0);
        push_src(1, 8'h22, 1'b0, 50);
        push_src(1, 8'h33, 1'b1, 0);
        push_src(0, 8'h0F, 1'b1, 0);
        push_exp(1, 8'h11);
        push_exp(1, 8'h22);
        push_exp(1, 8'h33);
        push_exp(0, 8'h0F);
        drain(600);
        check_eq("r39_no_err", err_timeout, 0);

        // Transmitter never acknowledges.
        no_ack = 1'b1;
        push_src(2, 8'h77, 1'b1, 0);
        push_exp(2, 8'h77);
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            @(negedge clk);
            found = tx_start;
        end
        check_eq("r40_start_seen", found, 1);
        k = 0;
        while (!err_timeout && k < 4 * AckTo) begin
            @(negedge clk);
            k++;
        end
        check_eq("r40_err_latency", k, AckTo);
        check_eq("r40_idle", active, 0);
        no_ack = 1'b0;
        drain(100);
        check_eq("r40_err_sticky", err_timeout, 1);

        // Reset while the byte is in flight.
        push_src(2, 8'h42, 1'b1, 0);
        push_exp(2, 8'h42);
        found = 1'b0;
        for (int j = 0; j < 40 && !found; j++) begin
            @(negedge clk);
            found = tx_busy;
        end
        check_eq("r41_busy_seen", found, 1);
        @(negedge clk);
        check_eq("r41_err_still", err_timeout, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("r41_active_before", active, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("r41_tx_start", tx_start, 0);
        check_eq("r41_tx_data", tx_data, 0);
        check_eq("r41_ready", req_ready, 0);
        check_eq("r41_active", active, 0);
        check_eq("r41_grant", grant_id, 0);
        check_eq("r41_err", err_timeout, 0);
        @(negedge clk);
        check_eq("r41_no_start_after", tx_start, 0);
        drain(300);
        push_src(1, 8'h61, 1'b1, 0);
        push_src(3, 8'h63, 1'b1, 0);
        push_exp(1, 8'h61);
        push_exp(3, 8'h63);
        drain(300);

        // Loopback at 50 MHz / 115200 baud.
        bit_cycles = 434;
        push_src(0, 8'hA5, 1'b1, 0);
        push_src(1, 8'h3C, 1'b1, 0);
        push_exp(0, 8'hA5);
        push_exp(1, 8'h3C);
        drain(12000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
